// File: rtl/alu_issue_ctrl.sv
// Command FIFO plus a three-state issue controller that drives an ALU and holds each result until it is consumed.
// Optional build macro ALU_ISSUE_TIMEOUT_EN adds an ISSUE watchdog and the err_to output.
module alu_issue_ctrl #(
   parameter int PA_DATA_WIDTH = 32,
   parameter int PA_FNCT_SEL   = 9,
   parameter int PA_FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_b,
   input  logic                              cmd_vld,
   output logic                              cmd_rdy,
   input  logic [PA_DATA_WIDTH-1:0]          cmd_a,
   input  logic [PA_DATA_WIDTH-1:0]          cmd_b,
   input  logic [PA_FNCT_SEL-1:0]            cmd_fnct,
   output logic [PA_DATA_WIDTH-1:0]          inp_a,
   output logic [PA_DATA_WIDTH-1:0]          inp_b,
   output logic [PA_FNCT_SEL-1:0]            fnct_sel,
   output logic                              alu_req,
   input  logic [PA_DATA_WIDTH-1:0]          alu_output,
   input  logic                              cf,
   input  logic                              zf,
   input  logic                              nf,
   input  logic                              vf,
   input  logic                              alu_ack,
   output logic                              res_vld,
   input  logic                              res_rdy,
   output logic [PA_DATA_WIDTH-1:0]          res_data,
   output logic [3:0]                        res_flags,
`ifdef ALU_ISSUE_TIMEOUT_EN
   output logic                              err_to,
`endif
   output logic [$clog2(PA_FIFO_DEPTH):0]    fifo_level
);

   localparam int PW = $clog2(PA_FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int EW = 2*PA_DATA_WIDTH + PA_FNCT_SEL;

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t                   state_reg, state_next;
   logic [EW-1:0]            mem [PA_FIFO_DEPTH];
   logic [PW-1:0]            wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]            level_reg;
   logic                     ready_en_reg;
   logic [PA_DATA_WIDTH-1:0] op_a_reg, op_b_reg;
   logic [PA_FNCT_SEL-1:0]   op_f_reg;
   logic [PA_DATA_WIDTH-1:0] res_data_reg;
   logic [3:0]               res_flags_reg;
   logic                     fifo_push, fifo_pop, res_cap, to_fire;

   // ready_en_reg keeps cmd_rdy low until the first edge after reset release
   assign cmd_rdy    = ready_en_reg && (level_reg < LW'(PA_FIFO_DEPTH));
   assign fifo_push  = cmd_vld && cmd_rdy;
   assign fifo_level = level_reg;
   assign inp_a      = op_a_reg;
   assign inp_b      = op_b_reg;
   assign fnct_sel   = op_f_reg;
   assign alu_req    = (state_reg == ISSUE);
   assign res_vld    = (state_reg == HOLD);
   assign res_data   = res_data_reg;
   assign res_flags  = res_flags_reg;

`ifdef ALU_ISSUE_TIMEOUT_EN
   logic [7:0] wd_reg;
   logic       err_reg;
   logic       wd_expired;

   // 255th consecutive ISSUE cycle without an acknowledge
   assign wd_expired = (wd_reg == 8'd254);
   assign err_to     = err_reg;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wd_reg  <= '0;
         err_reg <= 1'b0;
      end else begin
         wd_reg <= (state_reg == ISSUE && state_next == ISSUE) ? wd_reg + 8'd1 : 8'd0;
         if (to_fire)
            err_reg <= 1'b1;
         else if (state_reg == HOLD && res_rdy)
            err_reg <= 1'b0;
      end
   end
`else
   logic wd_expired;
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      fifo_pop   = 1'b0;
      res_cap    = 1'b0;
      to_fire    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (level_reg != '0) begin
               fifo_pop   = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (alu_ack) begin
               res_cap    = 1'b1;
               state_next = HOLD;
            end else if (wd_expired) begin
               to_fire    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (res_rdy) begin
               if (level_reg != '0) begin
                  fifo_pop   = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Storage array carries no reset so it can map to RAM
   always_ff @(posedge clk) begin
      if (fifo_push)
         mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_fnct};
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         ready_en_reg  <= 1'b0;
         op_a_reg      <= '0;
         op_b_reg      <= '0;
         op_f_reg      <= '0;
         res_data_reg  <= '0;
         res_flags_reg <= '0;
      end else begin
         state_reg    <= state_next;
         ready_en_reg <= 1'b1;
         if (fifo_push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (fifo_pop) begin
            rd_ptr_reg                     <= rd_ptr_reg + PW'(1);
            {op_a_reg, op_b_reg, op_f_reg} <= mem[rd_ptr_reg];
         end
         case ({fifo_push, fifo_pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
         if (res_cap) begin
            res_data_reg  <= alu_output;
            res_flags_reg <= {cf, zf, nf, vf};
         end else if (to_fire) begin
            res_data_reg  <= '0;
            res_flags_reg <= 4'b0000;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: single op, flags, fill/backpressure ordering, mid-issue reset, optional timeout.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_b;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [31:0] cmd_a, cmd_b;
   logic [8:0]  cmd_fnct;
   logic [31:0] inp_a, inp_b;
   logic [8:0]  fnct_sel;
   logic        alu_req;
   logic [31:0] alu_output;
   logic        cf, zf, nf, vf;
   logic        alu_ack;
   logic        res_vld;
   logic        res_rdy;
   logic [31:0] res_data;
   logic [3:0]  res_flags;
   logic [2:0]  fifo_level;
`ifdef ALU_ISSUE_TIMEOUT_EN
   logic        err_to;
`endif

   int errors = 0;
   int checks = 0;

   alu_issue_ctrl dut (
      .clk(clk), .rst_b(rst_b),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fnct(cmd_fnct),
      .inp_a(inp_a), .inp_b(inp_b), .fnct_sel(fnct_sel), .alu_req(alu_req),
      .alu_output(alu_output), .cf(cf), .zf(zf), .nf(nf), .vf(vf), .alu_ack(alu_ack),
      .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_flags(res_flags),
`ifdef ALU_ISSUE_TIMEOUT_EN
      .err_to(err_to),
`endif
      .fifo_level(fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int dly [5] = '{0, 2, 1, 3, 0};
   int bp  [5] = '{1, 0, 2, 0, 1};

   initial begin
      rst_b = 1'b0; cmd_vld = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fnct = '0;
      alu_output = '0; cf = 1'b0; zf = 1'b0; nf = 1'b0; vf = 1'b0;
      alu_ack = 1'b0; res_rdy = 1'b0;

      // reset state
      #12;
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_alu_req", alu_req, 0);
      chk("rst_res_vld", res_vld, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_inp_a", inp_a, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_flags", res_flags, 0);
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      chk("rel_rdy_before_edge", cmd_rdy, 0);
      tick();
      chk("rel_rdy_after_edge", cmd_rdy, 1);

      // single op: 5 + 7 with ack three cycles after request
      cmd_vld = 1'b1; cmd_a = 32'd5; cmd_b = 32'd7; cmd_fnct = 9'd1;
      tick();
      cmd_vld = 1'b0;
      chk("op_level_after_accept", fifo_level, 1);
      chk("op_req_not_yet", alu_req, 0);
      tick();
      chk("op_req_high", alu_req, 1);
      chk("op_inp_a", inp_a, 5);
      chk("op_inp_b", inp_b, 7);
      chk("op_fnct", fnct_sel, 1);
      chk("op_level_popped", fifo_level, 0);
      tick();
      tick();
      chk("op_req_held", alu_req, 1);
      alu_output = 32'd12; alu_ack = 1'b1;
      tick();
      alu_ack = 1'b0;
      chk("op_req_dropped", alu_req, 0);
      chk("op_res_vld", res_vld, 1);
      chk("op_res_data", res_data, 12);
      chk("op_res_flags", res_flags, 4'b0000);
      tick();
      chk("op_res_vld_held", res_vld, 1);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      chk("op_res_vld_clr", res_vld, 0);
      chk("op_idle_req", alu_req, 0);

      // flags, and acknowledge ignored outside ISSUE
      cmd_vld = 1'b1; cmd_a = 32'd9; cmd_b = 32'd9; cmd_fnct = 9'd2;
      tick();
      cmd_vld = 1'b0;
      tick();
      alu_output = 32'd0; cf = 1'b1; zf = 1'b1; alu_ack = 1'b1;
      tick();
      cf = 1'b0; zf = 1'b0;
      alu_output = 32'd99;
      chk("flg_res_flags", res_flags, 4'b1100);
      chk("flg_res_data", res_data, 0);
      tick();
      alu_ack = 1'b0;
      chk("flg_ack_in_hold_ignored", res_data, 0);
      chk("flg_hold_stays", res_vld, 1);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      alu_ack = 1'b1;
      tick();
      alu_ack = 1'b0;
      chk("flg_ack_in_idle_ignored", res_vld, 0);

      // fill: five pushes with the ALU stalled, sixth refused
      for (int i = 0; i < 5; i++) begin
         cmd_vld = 1'b1; cmd_a = 32'(10 + i); cmd_b = 32'd0; cmd_fnct = 9'd3;
         tick();
      end
      chk("fill_level", fifo_level, 4);
      chk("fill_rdy_low", cmd_rdy, 0);
      chk("fill_head_issued", inp_a, 10);
      cmd_a = 32'd99;
      tick();
      cmd_vld = 1'b0;
      chk("fill_sixth_refused", fifo_level, 4);

      // drain in order with varied ack delay and result backpressure
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ord_req_%0d", i), alu_req, 1);
         chk($sformatf("ord_inp_a_%0d", i), inp_a, 32'(10 + i));
         for (int d = 0; d < dly[i]; d++) tick();
         alu_output = 32'(200 + i); alu_ack = 1'b1;
         tick();
         alu_ack = 1'b0;
         chk($sformatf("ord_res_%0d", i), res_data, 32'(200 + i));
         for (int d = 0; d < bp[i]; d++) tick();
         chk($sformatf("ord_vld_%0d", i), res_vld, 1);
         res_rdy = 1'b1;
         tick();
         res_rdy = 1'b0;
      end
      chk("ord_done_req", alu_req, 0);
      chk("ord_done_vld", res_vld, 0);
      chk("ord_done_level", fifo_level, 0);

      // reset while issuing with two commands queued
      cmd_vld = 1'b1; cmd_a = 32'd1;
      tick();
      cmd_a = 32'd2;
      tick();
      cmd_a = 32'd3;
      tick();
      cmd_vld = 1'b0;
      chk("rmid_req", alu_req, 1);
      chk("rmid_level", fifo_level, 2);
      #2;
      rst_b = 1'b0;
      #1;
      chk("rmid_req_async", alu_req, 0);
      chk("rmid_level_async", fifo_level, 0);
      chk("rmid_vld_async", res_vld, 0);
      chk("rmid_rdy_async", cmd_rdy, 0);
      #3;
      rst_b = 1'b1;
      alu_ack = 1'b1; alu_output = 32'd77;
      res_rdy = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      alu_ack = 1'b0; res_rdy = 1'b0;
      chk("rmid_no_result", res_vld, 0);
      chk("rmid_no_issue", alu_req, 0);
      chk("rmid_res_data", res_data, 0);

`ifdef ALU_ISSUE_TIMEOUT_EN
      // watchdog: 255 ISSUE cycles without ack
      cmd_vld = 1'b1; cmd_a = 32'd7; cmd_b = 32'd1; cmd_fnct = 9'd4;
      tick();
      cmd_vld = 1'b0;
      tick();
      for (int i = 0; i < 254; i++) tick();
      chk("to_req_before", alu_req, 1);
      chk("to_err_before", err_to, 0);
      tick();
      chk("to_req_drop", alu_req, 0);
      chk("to_res_vld", res_vld, 1);
      chk("to_err", err_to, 1);
      chk("to_res_data", res_data, 0);
      chk("to_res_flags", res_flags, 0);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      chk("to_err_clr", err_to, 0);
      cmd_vld = 1'b1; cmd_a = 32'd8;
      tick();
      cmd_vld = 1'b0;
      tick();
      chk("to_next_inp_a", inp_a, 8);
      alu_output = 32'd55; alu_ack = 1'b1;
      tick();
      alu_ack = 1'b0;
      chk("to_next_res", res_data, 55);
      chk("to_next_err", err_to, 0);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter PA_DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter PA_FNCT_SEL, default 9, function-select width.
REQ-003 SHALL have parameter PA_FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports cmd_vld input 1, cmd_rdy output 1: command handshake, transfer when both high.
REQ-007 SHALL have ports cmd_a, cmd_b input PA_DATA_WIDTH and cmd_fnct input PA_FNCT_SEL: command payload.
REQ-008 SHALL have ports inp_a, inp_b output PA_DATA_WIDTH, fnct_sel output PA_FNCT_SEL, alu_req output 1: ALU drive.
REQ-009 SHALL have ports alu_output input PA_DATA_WIDTH, cf/zf/nf/vf input 1 each, alu_ack input 1: ALU return.
REQ-010 SHALL have ports res_vld output 1, res_rdy input 1, res_data output PA_DATA_WIDTH, res_flags output 4 ({cf,zf,nf,vf}): result handshake.
REQ-011 SHALL have port fifo_level output $clog2(PA_FIFO_DEPTH)+1: queued command count.

Function
REQ-012 SHALL buffer commands in a FIFO; cmd_rdy = (fifo_level < PA_FIFO_DEPTH), combinational from registered level.
REQ-013 SHALL wrap read/write pointers modulo PA_FIFO_DEPTH; simultaneous push and pop SHALL leave fifo_level unchanged, including when full (pop frees the slot same cycle only at next edge; cmd_rdy stays low while full).
REQ-014 SHALL implement FSM IDLE -> ISSUE -> HOLD -> IDLE.
REQ-015 IDLE: if FIFO non-empty, pop head into operand registers and go to ISSUE next edge; alu_req=0.
REQ-016 ISSUE: alu_req=1, inp_a/inp_b/fnct_sel held stable from operand registers; on alu_ack=1 capture alu_output and flags into result registers, deassert alu_req next cycle, go to HOLD.
REQ-017 alu_req SHALL be high for at least one cycle and never re-asserted in the cycle following alu_ack.
REQ-018 HOLD: res_vld=1, res_data/res_flags stable; on res_rdy=1 go to IDLE; if FIFO non-empty at that edge pop next command directly and go to ISSUE (back-to-back, one bubble max).
REQ-019 alu_ack outside ISSUE SHALL be ignored.
REQ-020 Minimum issue-to-result latency: command accepted edge N -> alu_req high cycle N+2 (empty FIFO, IDLE).
REQ-021 Commands SHALL be issued strictly in acceptance order; no command lost or duplicated.

Reset
REQ-022 rst_b low SHALL asynchronously force: state IDLE, FIFO empty, fifo_level=0, alu_req=0, res_vld=0, res_data=0, res_flags=0, inp_a=0, inp_b=0, fnct_sel=0.
REQ-023 cmd_rdy SHALL be 0 while rst_b low and 1 from first edge after release.
REQ-024 Reset asserted mid-ISSUE or mid-HOLD SHALL discard the in-flight command and queued commands; no result delivered.

Configuration
REQ-025 Macro ALU_ISSUE_TIMEOUT_EN SHALL compile in an 8-bit watchdog counting ISSUE cycles.
REQ-026 With ALU_ISSUE_TIMEOUT_EN: 255 consecutive ISSUE cycles without alu_ack SHALL drop alu_req, go to HOLD with res_data=0, res_flags=4'b0000, and assert output err_to (1 bit) alongside res_vld until res_rdy.
REQ-027 Without ALU_ISSUE_TIMEOUT_EN: no counter, no err_to port; ISSUE waits indefinitely.

Verification
REQ-028 Single op: push a=5,b=7,fnct=add, ack 3 cycles after req with out=12,flags=0000 -> res_data=12, res_flags=0000, res_vld until res_rdy.
REQ-029 Fill: push 4 commands with res_rdy=0, ALU stalled -> fifo_level 4 (or 3 with one in ISSUE, then 4 after 5th), cmd_rdy=0 when full, 6th push not accepted.
REQ-030 Order: push a=1..4, random ack delays and res_rdy backpressure -> results returned in order 1..4, exactly once each.
REQ-031 Flags: ack with out=0, cf=1,zf=1 -> res_flags=4'b1100.
REQ-032 Reset mid-ISSUE with 2 queued -> alu_req=0 immediately, fifo_level=0, res_vld=0; no later result appears.
REQ-033 Timeout (macro on): withhold ack 255 cycles -> alu_req falls, res_vld=1, err_to=1, res_data=0; next command issues normally.
